// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - four-digit BCD up/down counter with prescaler, load and wrap pulse
// Every output is a flop; load beats a coincident step, reset beats everything.

module bcd_updown_counter #(
  parameter int DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cw,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        tick,
  output logic        wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic [15:0]   r_digits;
  logic          r_tick;
  logic          r_wrap;

  logic          w_step;
  logic [15:0]   w_next_digits;
  logic          w_full_range;
  logic          w_chain;
  logic [3:0]    w_nib;
  logic [15:0]   w_load_clamped;

  assign w_step = en && (r_presc == PRESC_LAST);

  // Ripple the carry/borrow from digit 0 upward; a carry out of digit 3 means full-range wrap.
  always_comb begin
    w_next_digits = r_digits;
    w_chain       = 1'b1;
    w_nib         = 4'd0;
    for (int k = 0; k < 4; k++) begin
      w_nib = r_digits[4*k +: 4];
      if (w_chain) begin
        if (cw) begin
          if (w_nib >= 4'd9) begin
            w_next_digits[4*k +: 4] = 4'd0;
          end else begin
            w_next_digits[4*k +: 4] = w_nib + 4'd1;
            w_chain = 1'b0;
          end
        end else begin
          if (w_nib == 4'd0) begin
            w_next_digits[4*k +: 4] = 4'd9;
          end else begin
            w_next_digits[4*k +: 4] = w_nib - 4'd1;
            w_chain = 1'b0;
          end
        end
      end
    end
    w_full_range = w_chain;
  end

  always_comb begin
    w_load_clamped = load_val;
    for (int k = 0; k < 4; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        w_load_clamped[4*k +: 4] = 4'd9;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_digits <= 16'h0000;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (load) begin
      r_presc  <= '0;
      r_digits <= w_load_clamped;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_wrap <= w_step && w_full_range;
      if (en) begin
        r_presc <= w_step ? '0 : r_presc + PW'(1);
      end
      if (w_step) begin
        r_digits <= w_next_digits;
      end
    end
  end

  assign digits = r_digits;
  assign tick   = r_tick;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench driving DIV=4 and DIV=1 instances with shared stimulus
// Expected outputs come from an integer-valued model of the count; a monitor pops and compares each cycle.

module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cw = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] digits4, digits1;
  logic        tick4, tick1, wrap4, wrap1;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .en(en), .cw(cw), .load(load), .load_val(load_val),
    .digits(digits4), .tick(tick4), .wrap(wrap4)
  );

  bcd_updown_counter #(.DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .cw(cw), .load(load), .load_val(load_val),
    .digits(digits1), .tick(tick1), .wrap(wrap1)
  );

  typedef struct {
    logic [15:0] d4;
    logic        t4;
    logic        w4;
    logic [15:0] d1;
    logic        t1;
    logic        w1;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  bit running = 1'b0;

  // Model state: count as an integer 0..9999 and an integer prescaler phase.
  int m_val[2];
  int m_cnt[2];
  bit m_tick[2];
  bit m_wrap[2];
  int m_div[2] = '{4, 1};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int r;
    int n;
    int scale;
    r = 0;
    scale = 1;
    for (int k = 0; k < 4; k++) begin
      n = int'((lv >> (4 * k)) & 16'h000F);
      if (n > 9) n = 9;
      r = r + n * scale;
      scale = scale * 10;
    end
    return r;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit step;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_val[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
      end else if (load) begin
        m_val[i] = load_to_int(load_val); m_cnt[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
      end else begin
        step = en && (m_cnt[i] == m_div[i] - 1);
        m_tick[i] = step;
        m_wrap[i] = 0;
        if (en) m_cnt[i] = step ? 0 : m_cnt[i] + 1;
        if (step) begin
          if (cw) begin
            m_wrap[i] = (m_val[i] == 9999);
            m_val[i] = (m_val[i] + 1) % 10000;
          end else begin
            m_wrap[i] = (m_val[i] == 0);
            m_val[i] = (m_val[i] + 9999) % 10000;
          end
        end
      end
    end
    e.d4 = to_bcd(m_val[0]); e.t4 = m_tick[0]; e.w4 = m_wrap[0];
    e.d1 = to_bcd(m_val[1]); e.t1 = m_tick[1]; e.w1 = m_wrap[1];
    sb.push_back(e);
  endtask

  task automatic drive(input bit r, input bit e, input bit c, input bit l, input logic [15:0] lv);
    @(negedge clk);
    rst = r; en = e; cw = c; load = l; load_val = lv;
    @(posedge clk);
    running = 1'b1;
    model_edge();
  endtask

  task automatic run(input int n, input bit e, input bit c);
    for (int i = 0; i < n; i++) drive(1'b0, e, c, 1'b0, 16'h0000);
  endtask

  // Monitor: the DUT presents a full output word after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (digits4 !== e.d4 || tick4 !== e.t4 || wrap4 !== e.w4) begin
          n_err++;
          $display("FAIL div4_out t=%0t got d=%h t=%b w=%b want d=%h t=%b w=%b",
                   $time, digits4, tick4, wrap4, e.d4, e.t4, e.w4);
        end
        n_cmp++;
        if (digits1 !== e.d1 || tick1 !== e.t1 || wrap1 !== e.w1) begin
          n_err++;
          $display("FAIL div1_out t=%0t got d=%h t=%b w=%b want d=%h t=%b w=%b",
                   $time, digits1, tick1, wrap1, e.d1, e.t1, e.w1);
        end
      end else if (running) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty t=%0t got no expected entry want one", $time);
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);

    // Step timing: 40 enabled up cycles
    run(40, 1'b1, 1'b1);

    // Up wrap from 9998
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
    run(12, 1'b1, 1'b1);

    // Down borrow and down wrap
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1000);
    run(6, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    run(6, 1'b1, 1'b0);

    // Enable hold mid-interval
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    run(2, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);

    // Load colliding with a step, then reset colliding with load
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    run(3, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h5A3F);
    run(5, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777);
    run(2, 1'b1, 1'b1);

    // Load while disabled, clamping all nibbles
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    run(3, 1'b0, 1'b1);

    // Direction toggled every cycle from 0000
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, (i % 2) == 0, 1'b0, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 80 : 20)),
            ($urandom_range(0, 99) < 3),
            16'($urandom));
    end

    running = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIV, default 100000000, meaning clk cycles per count step (legal range 1 to 2^27).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable for the prescaler and the digits.
REQ-005 The block SHALL have port cw, input, 1 bit: direction; 1 = count up, 0 = count down.
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle request to preset the digits.
REQ-007 The block SHALL have port load_val, input, 16 bits: preset value, four BCD nibbles, [15:12] most significant.
REQ-008 The block SHALL have port digits, output, 16 bits: current count as four BCD nibbles, [3:0] least significant; feeds the seven-segment display multiplexer.
REQ-009 The block SHALL have port tick, output, 1 bit: registered one-cycle pulse marking each count step.
REQ-010 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).

Function
REQ-011 The prescaler SHALL count 0..DIV-1 only while en=1, and SHALL hold its value (not clear) while en=0.
REQ-012 When en=1 and prescaler = DIV-1, the prescaler SHALL return to 0 and a step SHALL occur in that same edge.
REQ-013 With DIV=1, a step SHALL occur on every enabled cycle.
REQ-014 On a step, digits SHALL update at that edge, and tick SHALL be 1 for exactly the following cycle.
REQ-015 Up step: digit 0 SHALL increment; any digit at 9 SHALL go to 0 and carry into the next digit; 9999 SHALL go to 0000.
REQ-016 Down step: digit 0 SHALL decrement; any digit at 0 SHALL go to 9 and borrow from the next digit; 0000 SHALL go to 9999.
REQ-017 wrap SHALL pulse high, coincident with tick, only on the full-range transitions of REQ-015/016.
REQ-018 cw SHALL be sampled at the step edge; a cw change between steps SHALL affect only the next step.
REQ-019 load=1 SHALL set digits to load_val at the next edge and SHALL clear the prescaler to 0.
REQ-020 On load, each load_val nibble above 9 SHALL be clamped to 9 independently.
REQ-021 Load SHALL NOT produce tick or wrap.
REQ-022 If load and a step coincide, the load SHALL win: the step is discarded, and tick and wrap stay 0.
REQ-023 load SHALL be honoured regardless of en.
REQ-024 digits SHALL never hold a nibble above 9.
REQ-025 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from input to output.

Reset
REQ-026 rst=1 SHALL, at the next edge, set digits=16'h0000, tick=0, wrap=0 and prescaler=0.
REQ-027 rst SHALL override load, en and an in-progress step.
REQ-028 Reset asserted mid-count SHALL discard the partial prescaler value.
REQ-029 Counting SHALL resume from 0000 with a full DIV-cycle interval after rst is released with en=1.

Verification (DIV=4 unless stated)
REQ-030 Step timing: rst, then en=1, cw=1 for 40 cycles -> tick every 4th cycle; digits 0000->0001->...->0010 after 10 ticks.
REQ-031 Up wrap: load 9998, cw=1, en=1 -> 9999, then 0000 with wrap=1 coincident with that tick, then 0001 with wrap=0.
REQ-032 Down borrow and wrap: load 1000, cw=0 -> 0999; load 0000, cw=0 -> 9999 with wrap=1.
REQ-033 Enable hold: en deasserted 2 cycles into an interval for 10 cycles -> no tick; re-enable -> tick after 2 more cycles, not 4.
REQ-034 Collisions: load 0x5A3F coincident with a step -> digits=5939, no tick; rst coincident with load -> digits=0000.
REQ-035 DIV=1 with cw toggled every cycle -> digits alternate 0001/0000, with tick high every cycle.
